rv32_alu: RTL and testbench

RV32I integer arithmetic/logic unit with a built-in branch comparator. It sits in the CPU execute stage. It computes the ALU result for OP and OP-IMM instructions from funct3 plus the sub/arith-shift qualifier, and evaluates branch conditions on the same two operands. Results are available combinationally for single-cycle execute, and also as registered copies for pipelined consumers.

---
 rtl/rv32_alu.sv | 72 +++++++
 tb/tb_rv32_alu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rv32_alu.sv
// RV32I execute-stage ALU with branch comparator.
// Combinational results plus one-cycle registered copies for pipelined consumers.
module rv32_alu (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  input  logic        i_sub,
  input  logic        i_arith_shift,
  input  logic [2:0]  i_branch_op,
  output logic [31:0] o_y,
  output logic        o_will_branch,
  output logic [31:0] o_y_q,
  output logic        o_will_branch_q
);

  logic [4:0]  shamt;
  logic        eq;
  logic        lt_signed;
  logic        lt_unsigned;
  logic [31:0] y_d;
  logic        branch_d;

  assign shamt       = i_b[4:0];
  assign eq          = (i_a == i_b);
  assign lt_signed   = ($signed(i_a) < $signed(i_b));
  assign lt_unsigned = (i_a < i_b);

  always_comb begin
    y_d = 32'h0;
    case (i_op)
      3'b000:  y_d = i_sub ? (i_a - i_b) : (i_a + i_b);
      3'b001:  y_d = i_a << shamt;
      3'b010:  y_d = {31'h0, lt_signed};
      3'b011:  y_d = {31'h0, lt_unsigned};
      3'b100:  y_d = i_a ^ i_b;
      3'b101:  y_d = i_arith_shift ? $unsigned($signed(i_a) >>> shamt) : (i_a >> shamt);
      3'b110:  y_d = i_a | i_b;
      3'b111:  y_d = i_a & i_b;
      default: y_d = 32'h0;
    endcase
  end

  // Reserved codes 010/011 fall through to not-taken.
  always_comb begin
    branch_d = 1'b0;
    case (i_branch_op)
      3'b000:  branch_d = eq;
      3'b001:  branch_d = ~eq;
      3'b100:  branch_d = lt_signed;
      3'b101:  branch_d = ~lt_signed;
      3'b110:  branch_d = lt_unsigned;
      3'b111:  branch_d = ~lt_unsigned;
      default: branch_d = 1'b0;
    endcase
  end

  assign o_y           = y_d;
  assign o_will_branch = branch_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_y_q           <= 32'h0;
      o_will_branch_q <= 1'b0;
    end else begin
      o_y_q           <= y_d;
      o_will_branch_q <= branch_d;
    end
  end

endmodule

// File: tb/tb_rv32_alu.sv
// Directed and randomized checks of rv32_alu; registered outputs are
// checked through a scoreboard queue filled when each vector is driven.
module tb_rv32_alu;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        sub;
  logic        arith;
  logic [2:0]  bop;
  logic [31:0] y;
  logic        wb;
  logic [31:0] y_q;
  logic        wb_q;

  typedef struct packed {
    logic [31:0] y;
    logic        br;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  rv32_alu dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_a             (a),
    .i_b             (b),
    .i_op            (op),
    .i_sub           (sub),
    .i_arith_shift   (arith),
    .i_branch_op     (bop),
    .o_y             (y),
    .o_will_branch   (wb),
    .o_y_q           (y_q),
    .o_will_branch_q (wb_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Reference model, written independently of the RTL structure.
  function automatic logic [31:0] model_y(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [2:0] mop, input logic msub,
                                          input logic mar);
    logic [4:0]  sh;
    logic [31:0] fill;
    logic        slt;
    sh = mb[4:0];
    if (ma[31] != mb[31]) slt = ma[31];
    else                  slt = (ma < mb);
    fill = 32'hFFFF_FFFF;
    case (mop)
      3'd0: model_y = msub ? (ma + ~mb + 32'd1) : (ma + mb);
      3'd1: model_y = ma << sh;
      3'd2: model_y = slt ? 32'd1 : 32'd0;
      3'd3: model_y = (ma < mb) ? 32'd1 : 32'd0;
      3'd4: model_y = ma ^ mb;
      3'd5: model_y = (ma >> sh) | ((mar && ma[31]) ? ~(fill >> sh) : 32'd0);
      3'd6: model_y = ma | mb;
      default: model_y = ma & mb;
    endcase
  endfunction

  function automatic logic model_br(input logic [31:0] ma, input logic [31:0] mb,
                                    input logic [2:0] mbop);
    logic slt;
    if (ma[31] != mb[31]) slt = ma[31];
    else                  slt = (ma < mb);
    case (mbop)
      3'd0: model_br = (ma == mb);
      3'd1: model_br = (ma != mb);
      3'd4: model_br = slt;
      3'd5: model_br = !slt;
      3'd6: model_br = (ma < mb);
      3'd7: model_br = (ma >= mb);
      default: model_br = 1'b0;
    endcase
  endfunction

  // Drive one vector, check combinational outputs, push the registered
  // expectation, clock once and pop/compare the registered outputs.
  task automatic step(input string tag, input logic rst,
                      input logic [31:0] sa, input logic [31:0] sb,
                      input logic [2:0] sop, input logic ssub, input logic sar,
                      input logic [2:0] sbop,
                      input logic [31:0] ey, input logic ebr);
    exp_t e;
    reset = rst; a = sa; b = sb; op = sop; sub = ssub; arith = sar; bop = sbop;
    #1;
    chk32({tag, "/y"}, y, ey);
    chk1({tag, "/br"}, wb, ebr);
    e.y  = rst ? 32'h0 : ey;
    e.br = rst ? 1'b0  : ebr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s/sb: observed empty queue expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk32({tag, "/y_q"}, y_q, e.y);
      chk1({tag, "/br_q"}, wb_q, e.br);
    end
    $display("step %-12s a=%h b=%h op=%0d sub=%0d ar=%0d bop=%0d rst=%0d y=%h br=%0d y_q=%h br_q=%0d",
             tag, sa, sb, sop, ssub, sar, sbop, rst, y, wb, y_q, wb_q);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop, rbop;
    logic        rsub, rar;

    reset = 1'b1; a = 32'h0; b = 32'h0; op = 3'd0; sub = 1'b0; arith = 1'b0; bop = 3'd2;
    @(posedge clk);
    #1;
    chk32("reset/y_q", y_q, 32'h0);
    chk1("reset/br_q", wb_q, 1'b0);

    step("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, 3'd0, 0, 0, 3'd2, 32'h0, 1'b0);
    step("sub_wrap", 0, 32'h0, 32'd1, 3'd0, 1, 0, 3'd2, 32'hFFFF_FFFF, 1'b0);
    step("srl", 0, 32'h8000_0000, 32'h24, 3'd5, 1, 0, 3'd2, 32'h0800_0000, 1'b0);
    step("sra", 0, 32'h8000_0000, 32'h24, 3'd5, 0, 1, 3'd2, 32'hF800_0000, 1'b0);
    step("sll", 0, 32'h1, 32'd31, 3'd1, 1, 1, 3'd2, 32'h8000_0000, 1'b0);
    step("slt", 0, 32'hFFFF_FFFF, 32'd1, 3'd2, 1, 1, 3'd3, 32'd1, 1'b0);
    step("sltu", 0, 32'hFFFF_FFFF, 32'd1, 3'd3, 0, 0, 3'd3, 32'd0, 1'b0);
    step("xor", 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4, 1, 1, 3'd2, 32'hFF00_FF00, 1'b0);
    step("or", 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd6, 1, 1, 3'd2, 32'hFFF0_FFF0, 1'b0);
    step("and", 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd7, 1, 1, 3'd2, 32'h00F0_00F0, 1'b0);

    // a=-2, b=3 (y is a+b=1 with op=000)
    step("beq", 0, 32'hFFFF_FFFE, 32'd3, 3'd0, 0, 0, 3'd0, 32'd1, 1'b0);
    step("bne", 0, 32'hFFFF_FFFE, 32'd3, 3'd0, 0, 0, 3'd1, 32'd1, 1'b1);
    step("blt", 0, 32'hFFFF_FFFE, 32'd3, 3'd0, 0, 0, 3'd4, 32'd1, 1'b1);
    step("bge", 0, 32'hFFFF_FFFE, 32'd3, 3'd0, 0, 0, 3'd5, 32'd1, 1'b0);
    step("bltu", 0, 32'hFFFF_FFFE, 32'd3, 3'd0, 0, 0, 3'd6, 32'd1, 1'b0);
    step("bgeu", 0, 32'hFFFF_FFFE, 32'd3, 3'd0, 0, 0, 3'd7, 32'd1, 1'b1);
    step("beq_eq", 0, 32'd5, 32'd5, 3'd0, 0, 0, 3'd0, 32'd10, 1'b1);
    step("bge_eq", 0, 32'd5, 32'd5, 3'd0, 0, 0, 3'd5, 32'd10, 1'b1);
    step("rsv010", 0, 32'd5, 32'd5, 3'd0, 0, 0, 3'd2, 32'd10, 1'b0);
    step("rsv011", 0, 32'd4, 32'd5, 3'd0, 0, 0, 3'd3, 32'd9, 1'b0);

    // Reset mid-stream: combinational path keeps tracking, registers clear.
    step("pre_rst", 0, 32'd7, 32'd7, 3'd0, 0, 0, 3'd0, 32'd14, 1'b1);
    step("in_rst", 1, 32'd7, 32'd7, 3'd0, 0, 0, 3'd0, 32'd14, 1'b1);
    step("post_rst", 0, 32'd7, 32'd7, 3'd0, 0, 0, 3'd0, 32'd14, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      rb   = (i % 4 == 0) ? ra : $urandom;
      rop  = 3'($urandom_range(0, 7));
      rbop = 3'($urandom_range(0, 7));
      rsub = 1'($urandom_range(0, 1));
      rar  = 1'($urandom_range(0, 1));
      step($sformatf("rand%0d", i), 0, ra, rb, rop, rsub, rar, rbop,
           model_y(ra, rb, rop, rsub, rar), model_br(ra, rb, rbop));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
